// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: IO-mapped interrupt controller.
// Synchronizes and edge-detects device requests into PEND, presents the
// highest-priority enabled request on intr, answers int_ack with a vector
// and tracks nested in-service state until EOI.
module io_intr_ctrl #(
    parameter int          NSRC        = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic [31:0]     Addr,
    inout  wire  [31:0]     Data,
    input  logic            IO_cs,
    input  logic            IO_rd,
    input  logic            IO_wr,
    input  logic            int_ack,
    input  logic [NSRC-1:0] irq_src,
    output logic [NSRC-1:0] intr
);

    localparam int IW = 3;

    typedef enum logic {S_IDLE, S_ACK} ack_st_t;

    ack_st_t                           r_state;
    logic [NSRC-1:0]                   r_pend, r_mask, r_insv;
    logic [5:0]                        r_vec;      // {valid, spurious, 0, idx[2:0]}
    logic                              r_wr_q;
    logic [SYNC_STAGES-1:0][NSRC-1:0]  r_sync;
    logic [NSRC-1:0]                   r_sync_q;

    logic            w_sel, w_wr_fire, w_take;
    logic [3:0]      w_off;
    logic [NSRC-1:0] w_wdata, w_rise, w_allow, w_pend_nx, w_insv_nx;
    logic [IW-1:0]   w_hp_intr, w_hp_insv;
    logic [31:0]     w_rdata;

    // Lowest set index wins; returns 0 for an empty vector.
    function automatic logic [IW-1:0] f_hp(input logic [NSRC-1:0] x);
        f_hp = '0;
        for (int i = NSRC-1; i >= 0; i--)
            if (x[i]) f_hp = IW'(i);
    endfunction

    assign w_sel     = IO_cs & (Addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = Addr[3:0];
    assign w_wdata   = Data[NSRC-1:0];
    // Commit a write only on the first edge of a strobe.
    assign w_wr_fire = w_sel & IO_wr & ~r_wr_q;
    assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_sync_q;
    assign w_take    = (r_state == S_IDLE) & int_ack;
    assign w_hp_intr = f_hp(intr);
    assign w_hp_insv = f_hp(r_insv);

    // Upper data bits are never stored; fold them away explicitly.
    wire w_unused = ^{Data[31:NSRC]};

    // Sources strictly above the highest in-service priority may interrupt.
    always_comb begin
        w_allow = '0;
        for (int i = 0; i < NSRC; i++)
            w_allow[i] = (r_insv == '0) || (i < int'(w_hp_insv));
    end

    // Next PEND/INSV: clears first, then sets, so sets win on a shared bit.
    // EOI works on the old INSV before the ack adds its bit.
    always_comb begin
        w_pend_nx = r_pend;
        w_insv_nx = r_insv;
        if (w_wr_fire && w_off == 4'd4 && r_insv != '0)
            w_insv_nx[w_hp_insv] = 1'b0;
        if (w_take && intr != '0) begin
            w_pend_nx[w_hp_intr] = 1'b0;
            w_insv_nx[w_hp_intr] = 1'b1;
        end
        if (w_wr_fire && w_off == 4'd0) w_pend_nx = w_pend_nx & ~w_wdata;
        if (w_wr_fire && w_off == 4'd5) w_pend_nx = w_pend_nx | w_wdata;
        w_pend_nx = w_pend_nx | w_rise;
    end

    // Read mux, zero-extended; unmapped offsets read 0.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            4'd0:    w_rdata[NSRC-1:0] = r_pend;
            4'd1:    w_rdata[NSRC-1:0] = r_mask;
            4'd2:    w_rdata[NSRC-1:0] = r_insv;
            4'd3:    w_rdata[5:0]      = r_vec;
            default: w_rdata           = '0;
        endcase
    end

    // Bus released during reset so it floats immediately on assertion.
    assign Data = (reset & w_sel & IO_rd) ? w_rdata : 'z;

    // Request synchronizer and edge-detect history.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_sync   <= '0;
            r_sync_q <= '0;
        end else begin
            r_sync[0] <= irq_src;
            for (int k = 1; k < SYNC_STAGES; k++)
                r_sync[k] <= r_sync[k-1];
            r_sync_q <= r_sync[SYNC_STAGES-1];
        end
    end

    // Register file state and write-strobe history.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_mask <= '0;
            r_insv <= '0;
            r_wr_q <= 1'b0;
        end else begin
            r_pend <= w_pend_nx;
            r_insv <= w_insv_nx;
            r_wr_q <= IO_wr;
            if (w_wr_fire && w_off == 4'd1) r_mask <= w_wdata;
        end
    end

    // Ack FSM: one vector capture per int_ack assertion.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (int_ack) begin
                    r_state <= S_ACK;
                    if (intr != '0) r_vec <= {3'b100, w_hp_intr};
                    else            r_vec <= 6'b010000;
                end
                S_ACK:   if (!int_ack) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered presentation to the CPU.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) intr <= '0;
        else        intr <= r_pend & r_mask & w_allow;
    end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// tb_io_intr_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the controller.
module tb_io_intr_ctrl;

    localparam int          NSRC = 6;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic            sys_clk = 1'b0;
    logic            reset   = 1'b0;
    logic [31:0]     Addr    = '0;
    wire  [31:0]     Data;
    logic            IO_cs = 1'b0, IO_rd = 1'b0, IO_wr = 1'b0, int_ack = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic [NSRC-1:0] intr;
    logic            tb_drv   = 1'b0;
    logic [31:0]     tb_wdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    assign Data = tb_drv ? tb_wdata : 'z;
    pullup (Data);   // a released bus reads all ones

    always #5 sys_clk = ~sys_clk;

    io_intr_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
        .sys_clk(sys_clk), .reset(reset), .Addr(Addr), .Data(Data),
        .IO_cs(IO_cs), .IO_rd(IO_rd), .IO_wr(IO_wr), .int_ack(int_ack),
        .irq_src(irq_src), .intr(intr)
    );

    // ---------------- behavioural model ----------------
    bit [NSRC-1:0] m_pend, m_mask, m_insv, m_intr;
    int            m_vec;
    bit            m_inack, m_wrq;
    bit [NSRC-1:0] m_hist [SS+2];   // m_hist[k] = irq_src sampled k edges ago

    function automatic int lowest(bit [NSRC-1:0] x);
        for (int i = 0; i < NSRC; i++) if (x[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_reg(int off);
        case (off)
            0: return 32'(m_pend);
            1: return 32'(m_mask);
            2: return 32'(m_insv);
            3: return 32'(m_vec);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge sys_clk or negedge reset) begin
        bit            sel, fire, take;
        int            off, hi, hr;
        bit [NSRC-1:0] rise, pn, ins, nx;
        if (!reset) begin
            m_pend = '0; m_mask = '0; m_insv = '0; m_intr = '0;
            m_vec = 0; m_inack = 0; m_wrq = 0;
            for (int k = 0; k < SS+2; k++) m_hist[k] = '0;
        end else begin
            sel  = IO_cs && (Addr[31:4] == BASE[31:4]);
            off  = int'(Addr[3:0]);
            fire = sel && IO_wr && !m_wrq;
            take = int_ack && !m_inack;
            rise = m_hist[SS] & ~m_hist[SS+1];
            hi   = lowest(m_insv);
            for (int i = 0; i < NSRC; i++)
                nx[i] = m_pend[i] & m_mask[i] & (m_insv == 0 || i < hi);
            pn  = m_pend;
            ins = m_insv;
            if (fire && off == 4 && hi >= 0) ins[hi] = 1'b0;
            if (take) begin
                hr = lowest(m_intr);
                if (hr >= 0) begin
                    pn[hr]  = 1'b0;
                    ins[hr] = 1'b1;
                    m_vec   = 32 + hr;
                end else m_vec = 16;
            end
            if (fire && off == 0) pn = pn & ~tb_wdata[NSRC-1:0];
            if (fire && off == 5) pn = pn | tb_wdata[NSRC-1:0];
            if (fire && off == 1) m_mask = tb_wdata[NSRC-1:0];
            pn = pn | rise;
            m_pend = pn; m_insv = ins; m_intr = nx;
            if (!m_inack && int_ack) m_inack = 1;
            else if (m_inack && !int_ack) m_inack = 0;
            m_wrq = IO_wr;
            for (int k = SS+1; k > 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[1] = irq_src;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge sys_clk);
            check("intr", 32'(intr), 32'(m_intr));
            if (!tb_drv) begin
                if (reset && IO_cs && IO_rd && Addr[31:4] == BASE[31:4])
                    check("rdata", Data, m_reg(int'(Addr[3:0])));
                else
                    check("data_z", Data, 32'hFFFF_FFFF);
            end
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic io_write(int off, logic [31:0] d);
        Addr = BASE + 32'(off); IO_cs = 1; IO_wr = 1; tb_drv = 1; tb_wdata = d;
        tick();
        IO_cs = 0; IO_wr = 0; tb_drv = 0;
        tick();
    endtask

    task automatic io_read(int off, output logic [31:0] v);
        Addr = BASE + 32'(off); IO_cs = 1; IO_rd = 1;
        @(negedge sys_clk); #1;
        v = Data;
        tick();
        IO_cs = 0; IO_rd = 0;
    endtask

    task automatic rd_chk(string name, int off, logic [31:0] exp);
        logic [31:0] v;
        io_read(off, v);
        check(name, v, exp);
    endtask

    task automatic pulse(int i);
        irq_src[i] = 1'b1; tick(); irq_src[i] = 1'b0;
    endtask

    task automatic wait_intr(string name, logic [NSRC-1:0] exp, int budget);
        int n = 0;
        while (intr !== exp && n < budget) begin tick(); n++; end
        check(name, 32'(intr), 32'(exp));
    endtask

    task automatic do_ack();
        int_ack = 1; tick(2); int_ack = 0; tick(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int op, off, r;
        fork compare_loop(); join_none

        // 1: reset state, enable all, edge on source 3
        tick(2);
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_data_z", Data, 32'hFFFF_FFFF);
        reset = 1'b1; tick();
        io_write(1, 32'h3F);
        pulse(3);
        wait_intr("t1_intr", 6'b001000, SS+2);
        rd_chk("t1_pend", 0, 32'h08);

        // 2: ack with PEND=0x0A, then EOI
        pulse(1);
        wait_intr("t2_intr_pre", 6'h0A, SS+2);
        do_ack();
        rd_chk("t2_insv", 2, 32'h02);
        rd_chk("t2_pend", 0, 32'h08);
        rd_chk("t2_vec",  3, 32'h21);
        check("t2_intr_blk", 32'(intr), 32'd0);
        io_write(4, 32'd0);
        wait_intr("t2_intr_eoi", 6'h08, 2);

        // 3: nesting
        do_ack();
        rd_chk("t3_insv_a", 2, 32'h08);
        pulse(1);
        wait_intr("t3_nest_intr", 6'h02, SS+2);
        do_ack();
        rd_chk("t3_insv_b", 2, 32'h0A);
        pulse(5);
        tick(SS+3);
        check("t3_blk5", 32'(intr), 32'd0);
        rd_chk("t3_pend5", 0, 32'h20);
        io_write(4, 32'd0);
        tick(2);
        check("t3_blk5_eoi1", 32'(intr), 32'd0);
        io_write(4, 32'd0);
        wait_intr("t3_intr5", 6'h20, 3);

        // 4: spurious ack, held EOI strobe
        io_write(1, 32'h0);
        tick(2);
        do_ack();
        rd_chk("t4_vec_spur", 3, 32'h10);
        rd_chk("t4_insv_spur", 2, 32'h00);
        io_write(1, 32'h3F);
        wait_intr("t4_intr5", 6'h20, 3);
        do_ack();
        pulse(0);
        wait_intr("t4_intr0", 6'h01, SS+2);
        do_ack();
        rd_chk("t4_insv2", 2, 32'h21);
        Addr = BASE + 32'd4; IO_cs = 1; IO_wr = 1; tb_drv = 1; tb_wdata = 0;
        tick(4);
        IO_cs = 0; IO_wr = 0; tb_drv = 0;
        tick();
        rd_chk("t4_hold_eoi", 2, 32'h20);
        io_write(4, 32'd0);

        // 5: edge beats W1C; unmapped read; released bus
        io_write(5, 32'h04);
        irq_src[2] = 1'b1;
        tick(SS);
        io_write(0, 32'h04);
        rd_chk("t5_pend2", 0, 32'h04);
        irq_src[2] = 1'b0;
        rd_chk("t5_off9", 9, 32'h0);
        @(negedge sys_clk); #1;
        check("t5_z_nocs", Data, 32'hFFFF_FFFF);
        tick();

        // 6: reset during ACK
        int_ack = 1; tick(2);
        io_write(5, 32'h3F);
        rd_chk("t6_pend", 0, 32'h3F);
        Addr = BASE; IO_cs = 1; IO_rd = 1;
        @(negedge sys_clk); #1;
        reset = 1'b0; #1;
        check("t6_data_z", Data, 32'hFFFF_FFFF);
        check("t6_intr", 32'(intr), 32'd0);
        tick(2);
        reset = 1'b1;           // int_ack still high: IDLE takes it at once
        tick();
        IO_cs = 0; IO_rd = 0;
        tick(2);
        rd_chk("t6_vec", 3, 32'h10);
        rd_chk("t6_pend0", 0, 32'h0);
        rd_chk("t6_mask0", 1, 32'h0);
        rd_chk("t6_insv0", 2, 32'h0);
        int_ack = 0; tick(2);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ NSRC'($urandom);
            if ($urandom_range(0, 3) == 0) int_ack = ~int_ack;
            if (!(IO_wr && $urandom_range(0, 1) == 1)) begin
                IO_cs = 0; IO_rd = 0; IO_wr = 0; tb_drv = 0;
                op  = int'($urandom_range(0, 9));
                r   = int'($urandom_range(0, 9));
                off = (r < 8) ? r : int'($urandom_range(6, 15));
                Addr = (($urandom_range(0, 9) == 0) ? 32'h200 : BASE) + 32'(off);
                if (op < 3) begin
                    IO_cs = 1; IO_rd = 1;
                end else if (op < 6) begin
                    IO_cs = 1; IO_wr = 1; tb_drv = 1;
                    tb_wdata = $urandom;
                    if (off == 0) tb_wdata = tb_wdata & $urandom;
                end else if (op == 6) begin
                    IO_rd = 1;
                end
            end
            tick();
        end
        IO_cs = 0; IO_rd = 0; IO_wr = 0; tb_drv = 0; irq_src = '0; int_ack = 0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
